// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write path.
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int NUM_REGS   = 32;

   // One buffered register write.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wb_entry_t;

   // One-hot register select, used to build the pending-write mask.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
      reg_onehot = NUM_REGS'(1) << a;
   endfunction

endpackage

// File: rtl/regfile_wr_ctrl_if.sv
// Producer-side handshake bundle for the write controller: the load-return
// channel and the ALU channel.
//
// Handshake: a result transfers on a rising clk edge where valid and ready are
// both high. The producer holds addr/data stable while valid is high; ready is
// computed by the controller from registered occupancy only and never looks at
// the valid of its own channel.
interface regfile_wr_ctrl_if;
   import regfile_pkg::*;

   logic                  ld_valid;
   logic                  ld_ready;
   logic [REG_ADDR_W-1:0] ld_waddr;
   logic [REG_DATA_W-1:0] ld_wdata;

   logic                  alu_valid;
   logic                  alu_ready;
   logic [REG_ADDR_W-1:0] alu_waddr;
   logic [REG_DATA_W-1:0] alu_wdata;

   // Producers (load unit, ALU).
   modport master (
      output ld_valid, ld_waddr, ld_wdata, alu_valid, alu_waddr, alu_wdata,
      input  ld_ready, alu_ready
   );

   // Write controller.
   modport slave (
      input  ld_valid, ld_waddr, ld_wdata, alu_valid, alu_waddr, alu_wdata,
      output ld_ready, alu_ready
   );

endinterface

// File: rtl/regfile_wr_ctrl_wb_fifo2i.sv
// wb_fifo2i: DEPTH-entry in-order queue with two write ports and one read port.
// Port 0 is always the older of two same-cycle pushes; port 1 is only used
// together with port 0. The caller guarantees it never pushes more than the
// free space.
// Per-entry valid/addr outputs exist only when REGFILE_WR_SCOREBOARD_EN is
// defined, since only the pending-mask decoder consumes them.
module wb_fifo2i
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push0,
   input  wb_entry_t               ent0,
   input  logic                    push1,
   input  wb_entry_t               ent1,
   input  logic                    pop,
   output logic [CW-1:0]           count,
   output wb_entry_t               head
`ifdef REGFILE_WR_SCOREBOARD_EN
   ,
   output logic [DEPTH-1:0]                  ent_valid,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0]  ent_addr
`endif
);

   localparam int PW = $clog2(DEPTH);

   wb_entry_t      mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;

   // Pointer and occupancy update; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
         rd_ptr <= rd_ptr + PW'(pop);
         count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
      end
   end

   // Storage writes: port 0 at the tail, port 1 right behind it.
   always_ff @(posedge clk) begin
      if (push0) mem[wr_ptr] <= ent0;
      if (push1) mem[wr_ptr + PW'(1)] <= ent1;
   end

   assign head = mem[rd_ptr];

`ifdef REGFILE_WR_SCOREBOARD_EN
   // An entry is live when its distance from the head is below the count.
   always_comb begin
      ent_valid = '0;
      ent_addr  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ent_valid[i] = CW'(PW'(i) - rd_ptr) < count;
         ent_addr[i]  = mem[i].addr;
      end
   end
`endif

endmodule

// File: rtl/regfile_wr_ctrl.sv
// regfile_wr_ctrl: owns the register file's single write port. Merges load and
// ALU results into an in-order queue and retires one write per cycle.
// Build option: REGFILE_WR_SCOREBOARD_EN enables the pending-write mask;
// without it pend_mask is tied to zero and the mask decoder is not built.
module regfile_wr_ctrl
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   regfile_wr_ctrl_if.slave       prod,
   output logic                   we,
   output logic [REG_ADDR_W-1:0]  waddr,
   output logic [REG_DATA_W-1:0]  wdata,
   output logic [NUM_REGS-1:0]    pend_mask,
   output logic                   q_full,
   output logic                   q_empty
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0] count;
   logic [CW-1:0] free;
   wb_entry_t     head;
   wb_entry_t     ld_ent;
   wb_entry_t     alu_ent;
   wb_entry_t     ent0;
   logic          ld_keep;
   logic          alu_keep;
   logic          push0;
   logic          push1;

`ifdef REGFILE_WR_SCOREBOARD_EN
   logic [DEPTH-1:0]                 ent_valid;
   logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_addr;
`endif

   // Readies come from registered occupancy; the load channel has priority
   // for the last free slot, so the ALU is the one throttled first.
   always_comb begin
      free           = CW'(DEPTH) - count;
      prod.ld_ready  = (free >= CW'(1));
      prod.alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && !prod.ld_valid);
   end

   // Accept both handshakes, drop r0 writes, and compact survivors so the
   // load result (older) always lands on queue port 0.
   always_comb begin
      ld_ent   = '{addr: prod.ld_waddr,  data: prod.ld_wdata};
      alu_ent  = '{addr: prod.alu_waddr, data: prod.alu_wdata};
      ld_keep  = prod.ld_valid  && prod.ld_ready  && (prod.ld_waddr  != '0);
      alu_keep = prod.alu_valid && prod.alu_ready && (prod.alu_waddr != '0);
      push0    = ld_keep || alu_keep;
      push1    = ld_keep && alu_keep;
      ent0     = ld_keep ? ld_ent : alu_ent;
   end

   wb_fifo2i #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push0     (push0),
      .ent0      (ent0),
      .push1     (push1),
      .ent1      (alu_ent),
      .pop       (we),
      .count     (count),
      .head      (head)
`ifdef REGFILE_WR_SCOREBOARD_EN
      ,
      .ent_valid (ent_valid),
      .ent_addr  (ent_addr)
`endif
   );

   // Head of queue drives the write port; zeros when nothing is buffered.
   always_comb begin
      we      = (count != '0);
      waddr   = we ? head.addr : '0;
      wdata   = we ? head.data : '0;
      q_full  = (count == CW'(DEPTH));
      q_empty = (count == '0);
   end

`ifdef REGFILE_WR_SCOREBOARD_EN
   // Pending mask: union of destinations of all live entries; r0 never pends.
   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_valid[i]) pend_mask = pend_mask | reg_onehot(ent_addr[i]);
      end
      pend_mask[0] = 1'b0;
   end
`else
   assign pend_mask = '0;
`endif

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Bench for regfile_wr_ctrl: directed vectors, expected writes queued on
// acceptance, a negedge monitor retiring them against the write port.
module tb_regfile_wr_ctrl;
   import regfile_pkg::*;

   localparam int DEPTH = 4;

   logic                  clk;
   logic                  rst;
   logic                  we;
   logic [REG_ADDR_W-1:0] waddr;
   logic [REG_DATA_W-1:0] wdata;
   logic [NUM_REGS-1:0]   pend_mask;
   logic                  q_full;
   logic                  q_empty;

   int n_vec = 0;
   int n_err = 0;

   wb_entry_t exp_q[$];

   regfile_wr_ctrl_if prod_if ();

   regfile_wr_ctrl #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .prod      (prod_if.slave),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .pend_mask (pend_mask),
      .q_full    (q_full),
      .q_empty   (q_empty)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_pend(input logic [31:0] m);
`ifdef REGFILE_WR_SCOREBOARD_EN
      return m;
`else
      return (m & 32'h0);
`endif
   endfunction

   // One clock of stimulus. Readies are predicted from the bench's own queue
   // occupancy; accepted non-r0 results enter the expected queue after the edge.
   task automatic drive(input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        output logic l_acc, output logic a_acc);
      int   fr;
      logic lr, ar;
      #1;
      prod_if.ld_valid  = lv;
      prod_if.ld_waddr  = la;
      prod_if.ld_wdata  = ld;
      prod_if.alu_valid = av;
      prod_if.alu_waddr = aa;
      prod_if.alu_wdata = ad;
      fr = DEPTH - exp_q.size();
      lr = (fr >= 1);
      ar = (fr >= 2) || (fr == 1 && !lv);
      #1;
      check("ld_ready",  32'(prod_if.ld_ready),  32'(lr));
      check("alu_ready", 32'(prod_if.alu_ready), 32'(ar));
      l_acc = lv && lr;
      a_acc = av && ar;
      @(posedge clk);
      if (l_acc && la != 5'd0) exp_q.push_back('{addr: la, data: ld});
      if (a_acc && aa != 5'd0) exp_q.push_back('{addr: aa, data: ad});
   endtask

   task automatic idle(input int n);
      logic x, y;
      for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, x, y);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      wb_entry_t   e;
      logic [31:0] m;
      if (rst) begin
         m = 32'h0;
         foreach (exp_q[i]) m = m | (32'h1 << exp_q[i].addr);
         check("pend_mask", pend_mask, exp_pend(m));
         check("q_empty", 32'(q_empty), 32'(exp_q.size() == 0));
         check("q_full",  32'(q_full),  32'(exp_q.size() == DEPTH));
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("we",    32'(we),    32'h1);
            check("waddr", 32'(waddr), 32'(e.addr));
            check("wdata", wdata,      e.data);
         end else begin
            check("we_idle",    32'(we),    32'h0);
            check("waddr_idle", 32'(waddr), 32'h0);
            check("wdata_idle", wdata,      32'h0);
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic la, aa;
      int   n_res;
      rst = 1'b0;
      prod_if.ld_valid  = 1'b0;
      prod_if.ld_waddr  = '0;
      prod_if.ld_wdata  = '0;
      prod_if.alu_valid = 1'b0;
      prod_if.alu_waddr = '0;
      prod_if.alu_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_we",        32'(we),                32'h0);
      check("rst_waddr",     32'(waddr),             32'h0);
      check("rst_wdata",     wdata,                  32'h0);
      check("rst_pend",      pend_mask,              32'h0);
      check("rst_q_empty",   32'(q_empty),           32'h1);
      check("rst_q_full",    32'(q_full),            32'h0);
      check("rst_ld_ready",  32'(prod_if.ld_ready),  32'h1);
      check("rst_alu_ready", 32'(prod_if.alu_ready), 32'h1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      idle(2);

      // Single ALU write: r5 = 0x1234, presented the next cycle only.
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, la, aa);
      #1;
      check("single_we",    32'(we),    32'h1);
      check("single_waddr", 32'(waddr), 32'd5);
      check("single_wdata", wdata,      32'h1234);
      check("single_pend",  pend_mask,  exp_pend(32'h20));
      idle(1);
      #1;
      check("single_we_after",   32'(we),   32'h0);
      check("single_pend_after", pend_mask, 32'h0);

      // Dual intake to r7: load value retires before ALU value.
      drive(1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB, la, aa);
      #1;
      check("dual_first_addr", 32'(waddr), 32'd7);
      check("dual_first_data", wdata,      32'hAAAA);
      check("dual_pend",       pend_mask,  exp_pend(32'h80));
      idle(1);
      #1;
      check("dual_second_data", wdata, 32'hBBBB);
      idle(2);

      // r0 filtering: ALU r0 is accepted but dropped, load r3 is written.
      drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd0, 32'h99, la, aa);
      check("r0_ld_acc",  32'(la), 32'h1);
      check("r0_alu_acc", 32'(aa), 32'h1);
      #1;
      check("r0_waddr", 32'(waddr), 32'd3);
      check("r0_pend",  pend_mask,  exp_pend(32'h08));
      idle(3);

      // Backpressure: both producers valid every cycle until 20 results.
      n_res = 0;
      for (int c = 0; c < 60 && n_res < 20; c++) begin
         drive(1'b1, 5'((n_res % 31) + 1), 32'hD000_0000 | 32'(n_res),
               1'b1, 5'(((n_res + 11) % 31) + 1), 32'hE000_0000 | 32'(n_res + 1),
               la, aa);
         n_res += int'(la) + int'(aa);
      end
      check("bp_results", 32'(n_res >= 20), 32'h1);
      idle(DEPTH + 2);

      // Reset with three writes queued: nothing queued may be written later.
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, la, aa);
      drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, la, aa);
      check("pre_rst_depth", 32'(exp_q.size()), 32'd3);
      prod_if.ld_valid  = 1'b0;
      prod_if.alu_valid = 1'b0;
      #2;
      rst = 1'b0;
      exp_q.delete();
      #1;
      check("mid_rst_we",        32'(we),                32'h0);
      check("mid_rst_pend",      pend_mask,              32'h0);
      check("mid_rst_q_empty",   32'(q_empty),           32'h1);
      check("mid_rst_ld_ready",  32'(prod_if.ld_ready),  32'h1);
      check("mid_rst_alu_ready", 32'(prod_if.alu_ready), 32'h1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      idle(5);

      check("final_drain", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
